// File: rtl/usb_host_bus_if_pkg.sv
// Shared definitions for usb_host_bus_if: FSM state encoding, CTRL register layout,
// reset values and a small helper for sizing the phase counter.
package usb_host_bus_if_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StHold,
    StGap,
    StResp
  } state_e;

  // mem_cmd_addr bit that selects the local CTRL register instead of external space
  localparam int unsigned CtrlSelBit = 18;
  // CTRL register bit positions as seen on a read
  localparam int unsigned CtrlRstBit = 0;
  localparam int unsigned CtrlIrqBit = 1;
  // CTRL[0] resets low so the controller stays in reset until software releases it
  localparam logic CtrlRstVal = 1'b0;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/usb_host_bus_if_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset (resets to 0).
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset
//   d_i    : asynchronous input
//   q_o    : synchronized output, two edges of latency
module usb_host_bus_if_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/usb_host_bus_if.sv
// CPU-bus slave for the external USB host controller.
// Turns 32-bit mem_cmd accesses into two timed 16-bit asynchronous bus cycles
// (usb_cs_/usb_rd_/usb_wr_/usb_a/usb_d_*) and returns read data on mem_rsp.
// A local CTRL register (mem_cmd_addr[18]=1) drives usb_reset_ and reports the interrupt.
//   clk, reset_           : clock, asynchronous active-low reset
//   mem_cmd_*             : command port (accepted only in idle)
//   mem_rsp_ready/rdata   : one-cycle read response
//   usb_reset_            : controller reset from CTRL[0]
//   usb_cs_/rd_/wr_/a     : active-low strobes and half-word address
//   usb_d_o/usb_d_oe/usb_d_i : data bus toward the pad tristate
//   usb_irq/usb_irq_sync  : interrupt in / synchronized copy
// Optional feature macro: USB_IRQ_SYNC_EN enables the interrupt synchronizer.
module usb_host_bus_if
  import usb_host_bus_if_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 3,
  parameter int unsigned HOLD_CYCLES   = 1,
  parameter int unsigned GAP_CYCLES    = 1
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mem_cmd_sel,
  input  logic        mem_cmd_valid,
  output logic        mem_cmd_ready,
  input  logic        mem_cmd_wr,
  input  logic [18:0] mem_cmd_addr,
  input  logic [31:0] mem_cmd_wdata,
  input  logic [3:0]  mem_cmd_be,
  output logic        mem_rsp_ready,
  output logic [31:0] mem_rsp_rdata,
  output logic        usb_reset_,
  output logic        usb_cs_,
  output logic        usb_rd_,
  output logic        usb_wr_,
  output logic [16:0] usb_a,
  output logic [15:0] usb_d_o,
  output logic        usb_d_oe,
  input  logic [15:0] usb_d_i,
  input  logic        usb_irq,
  output logic        usb_irq_sync
);

  localparam int unsigned MaxCyc = max4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, GAP_CYCLES);
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);
  localparam logic [CntW-1:0] SetupLd  = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] StrobeLd = CntW'(STROBE_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLd   = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLd    = CntW'(GAP_CYCLES - 1);

  logic irq_sync;

`ifdef USB_IRQ_SYNC_EN
  usb_host_bus_if_sync2 u_irq_sync (
    .clk_i  (clk),
    .rst_ni (reset_),
    .d_i    (usb_irq),
    .q_o    (irq_sync)
  );
`else
  logic unused_irq;
  assign unused_irq = usb_irq;
  assign irq_sync   = 1'b0;
`endif

  // Byte offset within the word plays no role on a 16-bit half-word bus
  logic unused_addr;
  assign unused_addr = ^mem_cmd_addr[1:0];

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [15:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            be_hi_q, be_hi_d;
  logic            half_q, half_d;
  logic            ctrl_q, ctrl_d;
  logic            cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [16:0]     a_q, a_d;
  logic [15:0]     do_q, do_d;
  logic            oe_q, oe_d;
  logic            rsp_q, rsp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            accept, bus_act;

  assign accept = mem_cmd_valid & mem_cmd_sel & (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_hi_d = be_hi_q;
    half_d  = half_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    rsp_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          wr_d    = mem_cmd_wr;
          addr_d  = mem_cmd_addr[17:2];
          wdata_d = mem_cmd_wdata;
          be_hi_d = |mem_cmd_be[3:2];
          if (mem_cmd_addr[CtrlSelBit]) begin
            if (mem_cmd_wr) begin
              if (mem_cmd_be[0]) ctrl_d = mem_cmd_wdata[CtrlRstBit];
            end else begin
              rdata_d             = '0;
              rdata_d[CtrlRstBit] = ctrl_q;
              rdata_d[CtrlIrqBit] = irq_sync;
              rsp_d               = 1'b1;
              state_d             = StResp;
            end
          end else if (!mem_cmd_wr || (|mem_cmd_be)) begin
            // Writes skip the low half when only the upper bytes are enabled
            half_d  = mem_cmd_wr && !(|mem_cmd_be[1:0]);
            cnt_d   = SetupLd;
            state_d = StSetup;
          end
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          cnt_d   = StrobeLd;
          state_d = StStrobe;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            if (half_q) rdata_d[31:16] = usb_d_i;
            else        rdata_d[15:0]  = usb_d_i;
          end
          cnt_d   = HoldLd;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          if (!half_q && (!wr_q || be_hi_q)) begin
            half_d  = 1'b1;
            cnt_d   = GapLd;
            state_d = StGap;
          end else if (!wr_q) begin
            rsp_d   = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          cnt_d   = SetupLd;
          state_d = StSetup;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Bus outputs are registered from the next state so they align with it
    bus_act = (state_d == StSetup) || (state_d == StStrobe) || (state_d == StHold);
    cs_n_d  = !bus_act;
    rd_n_d  = !((state_d == StStrobe) && !wr_d);
    wr_n_d  = !((state_d == StStrobe) && wr_d);
    oe_d    = bus_act && wr_d;
    a_d     = bus_act ? {addr_d, half_d} : a_q;
    do_d    = oe_d ? (half_d ? wdata_d[31:16] : wdata_d[15:0]) : do_q;
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_hi_q <= 1'b0;
      half_q  <= 1'b0;
      ctrl_q  <= CtrlRstVal;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      a_q     <= '0;
      do_q    <= '0;
      oe_q    <= 1'b0;
      rsp_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_hi_q <= be_hi_d;
      half_q  <= half_d;
      ctrl_q  <= ctrl_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      a_q     <= a_d;
      do_q    <= do_d;
      oe_q    <= oe_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_cmd_ready = (state_q == StIdle);
  assign mem_rsp_ready = rsp_q;
  assign mem_rsp_rdata = rdata_q;
  assign usb_reset_    = ctrl_q;
  assign usb_cs_       = cs_n_q;
  assign usb_rd_       = rd_n_q;
  assign usb_wr_       = wr_n_q;
  assign usb_a         = a_q;
  assign usb_d_o       = do_q;
  assign usb_d_oe      = oe_q;
  assign usb_irq_sync  = irq_sync;

endmodule
